// File: rtl/adf4158_lock_monitor_if.sv
// Status/control bundle between the ADF4158 lock monitor and the radar controller.
interface adf4158_lock_monitor_if;
  logic        i_start;
  logic        i_muxout;
  logic        o_locked;
  logic        o_lock_fault;
  logic        o_busy;
  logic        o_lost_lock;
  logic [7:0]  o_lost_lock_cnt;
  logic [19:0] o_lock_time;

  modport slave (
    input  i_start, i_muxout,
    output o_locked, o_lock_fault, o_busy, o_lost_lock, o_lost_lock_cnt, o_lock_time
  );

  modport master (
    output i_start, i_muxout,
    input  o_locked, o_lock_fault, o_busy, o_lost_lock, o_lost_lock_cnt, o_lock_time
  );
endinterface

// File: rtl/adf4158_lock_monitor.sv
// Qualifies the ADF4158 MUXOUT digital lock detect into lock, timeout,
// acquisition-time and loss-of-lock status.
module adf4158_lock_monitor #(
  parameter logic [15:0] LOCK_CYCLES    = 16'd1000,
  parameter logic [15:0] UNLOCK_CYCLES  = 16'd8,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd400000
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  adf4158_lock_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  state_t      r_state;
  logic [1:0]  r_sync;
  logic [19:0] r_timer;
  logic [15:0] r_run_hi;
  logic [15:0] r_run_lo;
  logic [7:0]  r_lost_cnt;
  logic [19:0] r_lock_time;
  logic        r_lost_lock;

  logic        w_mux_s;
  logic [15:0] w_run_hi_inc;
  logic [15:0] w_run_lo_inc;
  logic [7:0]  w_lost_cnt_inc;

  assign w_mux_s        = r_sync[1];
  assign w_run_hi_inc   = (r_run_hi == '1)   ? r_run_hi   : r_run_hi + 16'd1;
  assign w_run_lo_inc   = (r_run_lo == '1)   ? r_run_lo   : r_run_lo + 16'd1;
  assign w_lost_cnt_inc = (r_lost_cnt == '1) ? r_lost_cnt : r_lost_cnt + 8'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_sync      <= '0;
      r_timer     <= '0;
      r_run_hi    <= '0;
      r_run_lo    <= '0;
      r_lost_cnt  <= '0;
      r_lock_time <= '0;
      r_lost_lock <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], bus.i_muxout};
      r_lost_lock <= 1'b0;
      // A start pulse outranks every state-local event, including a
      // simultaneous loss of lock, so restarts never count as loss events.
      if (bus.i_start) begin
        r_state  <= ST_ACQ;
        r_timer  <= '0;
        r_run_hi <= '0;
        r_run_lo <= '0;
      end else begin
        case (r_state)
          ST_ACQ: begin
            r_timer  <= r_timer + 20'd1;
            r_run_hi <= w_mux_s ? w_run_hi_inc : '0;
            if (w_mux_s && (r_run_hi == LOCK_CYCLES - 16'd1)) begin
              r_state     <= ST_LOCKED;
              r_lock_time <= r_timer;
              r_run_lo    <= '0;
            end else if (r_timer == TIMEOUT_CYCLES - 20'd1) begin
              r_state <= ST_FAULT;
            end
          end
          ST_LOCKED: begin
            if (!w_mux_s && (r_run_lo == UNLOCK_CYCLES - 16'd1)) begin
              r_state     <= ST_ACQ;
              r_lost_lock <= 1'b1;
              r_lost_cnt  <= w_lost_cnt_inc;
              r_timer     <= '0;
              r_run_hi    <= '0;
              r_run_lo    <= '0;
            end else begin
              r_run_lo <= w_mux_s ? '0 : w_run_lo_inc;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.o_locked        = (r_state == ST_LOCKED);
  assign bus.o_lock_fault    = (r_state == ST_FAULT);
  assign bus.o_busy          = (r_state == ST_ACQ);
  assign bus.o_lost_lock     = r_lost_lock;
  assign bus.o_lost_lock_cnt = r_lost_cnt;
  assign bus.o_lock_time     = r_lock_time;

endmodule

// File: doc/adf4158_lock_monitor.md
# adf4158_lock_monitor

Consumes the ADF4158 MUXOUT pin, with MUXOUT configured as digital lock detect, and qualifies it into a clean PLL-lock status for the radar controller. Acquisition is armed by a `start` pulse, normally the rising edge of the synthesizer driver's `config_done`. The block reports lock, acquisition timeout, lock-acquisition time and lost-lock events. It sits directly downstream of the ADF4158 configuration driver, on the same 40 MHz reference clock.

## Interface
- `LOCK_CYCLES`, default 16'd1000: consecutive sampled-high cycles required to declare lock; must be ≥1.
- `UNLOCK_CYCLES`, default 16'd8: consecutive sampled-low cycles while locked that declare loss of lock; must be ≥1.
- `TIMEOUT_CYCLES`, default 20'd400000 (10 ms at 40 MHz): acquisition budget; must be > `LOCK_CYCLES`.
- `clk`  in  1  40 MHz reference clock. Single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse; arms or restarts acquisition.
- `muxout`  in  1  raw ADF4158 MUXOUT pin; asynchronous.
- `locked`  out  1  qualified lock status.
- `lock_fault`  out  1  sticky acquisition timeout.
- `busy`  out  1  high while acquiring.
- `lost_lock`  out  1  one-cycle pulse on loss of lock.
- `lost_lock_cnt`  out  8  saturating count of loss-of-lock events.
- `lock_time`  out  20  acquisition duration, in cycles, of the most recent lock.

## Operation
- Synchronizer: `muxout` passes through two flops to produce `mux_s`. Reset value is 0.
- Counters:
  - `timer` is 20 bits.
  - `run_hi` and `run_lo` are 16 bits; both saturate.
- State IDLE (reset state):
  - All outputs are 0.
  - `start` moves the block to ACQ.
- State ACQ:
  - `busy` = 1.
  - `timer` increments every cycle, starting from 0 in the first ACQ cycle.
  - `run_hi` increments when `mux_s` = 1 and clears to 0 when `mux_s` = 0.
  - Lock condition: `mux_s` = 1 and `run_hi` == `LOCK_CYCLES`-1. On it, go to LOCKED and latch `lock_time` <= `timer`.
  - Timeout condition: otherwise, if `timer` == `TIMEOUT_CYCLES`-1, go to FAULT.
  - If lock and timeout occur in the same cycle, lock wins.
- State LOCKED:
  - `locked` = 1.
  - `run_lo` increments when `mux_s` = 0 and clears when `mux_s` = 1.
  - Loss condition: `mux_s` = 0 and `run_lo` == `UNLOCK_CYCLES`-1. On it:
    - pulse `lost_lock` for one cycle;
    - increment `lost_lock_cnt`, saturating at 255;
    - go to ACQ with `timer`, `run_hi` and `run_lo` cleared.
- State FAULT:
  - `lock_fault` = 1; `busy` = 0.
  - Leaves only on `start` (go to ACQ, `lock_fault` cleared) or on `rst`.
- `start` in ACQ or LOCKED restarts acquisition:
  - go to ACQ; clear `timer` and the run counters;
  - `locked` drops; no `lost_lock` pulse and no count change.
- `start` coincident with the loss condition: treat as a restart only. No pulse, no count change.
- `lock_time` holds its value until the next lock; only `rst` clears it.
- `lost_lock_cnt` is cleared only by `rst`.
- All outputs are registered and decoded from the state register, or are registered pulses.

## Timing
- `start` sampled at edge n: `busy` = 1 from cycle n+1, and `timer` = 0 in cycle n+1.
- Pin-to-`mux_s` latency: 2 cycles.
- Lock timing: if `mux_s` is first high in cycle k and stays high, `locked` = 1 from cycle k+`LOCK_CYCLES`. `lock_time` updates in the same cycle `locked` rises.
- Loss timing: if `mux_s` first falls in cycle j while locked and stays low, `lost_lock` is high in cycle j+`UNLOCK_CYCLES` only. In that same cycle `locked` = 0 and `busy` = 1.
- Timeout timing: with no lock, `lock_fault` = 1 from cycle n+1+`TIMEOUT_CYCLES`, and `busy` drops in the same cycle.
- `rst` asserted mid-operation takes effect at the next edge:
  - state returns to IDLE;
  - all counters and outputs clear, including `lost_lock_cnt` and `lock_time`;
  - synchronizer flops clear.
- `start` is ignored in any cycle where `rst` = 1.

## Test plan
All scenarios use parameters `LOCK_CYCLES`=4, `UNLOCK_CYCLES`=2, `TIMEOUT_CYCLES`=20.
- Clean lock: reset, `start` at cycle 10, `muxout` high from cycle 12 → `mux_s` high at 14, `locked` rises at cycle 18, `lock_time` = 6, `busy` falls at 18.
- Glitchy acquisition: `muxout` high for 3 cycles, low for 1, then held high → `run_hi` restarts after the low; `locked` rises 4 cycles after the second rise of `mux_s`; no `lock_fault`.
- Timeout: `start` at cycle 5, `muxout` held low → `lock_fault` = 1 and `busy` = 0 from cycle 26. A further `start` at cycle 40 clears `lock_fault` at 41; `muxout` high then locks normally.
- Loss of lock: once locked, a 1-cycle low on `muxout` → no event. A 2-cycle low → `lost_lock` pulses once, `lost_lock_cnt` goes 0→1, `locked` = 0, and re-acquisition begins (`timer` = 0).
- Saturation and restart: 260 forced loss events → `lost_lock_cnt` = 255. `start` while LOCKED → `locked` drops next cycle with no `lost_lock` pulse.
- Reset mid-ACQ and mid-LOCKED → all outputs 0 the cycle after `rst`; `start` asserted together with `rst` is ignored.
